// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and helpers for the calculator front end.
//   - 7-segment codes for digits 0..9 and blank (abcdefg.dp, a = MSB)
//   - LCD ASCII codes for blank and '0'
//   - operand-entry state codes
//   - bit positions of the keys inside the 12-bit push-switch vector
//   - decode_key(): turns a one-hot key pattern into digit/clear/enter flags
package calc_pkg;

    localparam int N_KEYS = 12;

    localparam logic [7:0] SEG_0   = 8'hFC;
    localparam logic [7:0] SEG_1   = 8'h60;
    localparam logic [7:0] SEG_2   = 8'hDA;
    localparam logic [7:0] SEG_3   = 8'hF2;
    localparam logic [7:0] SEG_4   = 8'h66;
    localparam logic [7:0] SEG_5   = 8'hB6;
    localparam logic [7:0] SEG_6   = 8'hBE;
    localparam logic [7:0] SEG_7   = 8'hE0;
    localparam logic [7:0] SEG_8   = 8'hFE;
    localparam logic [7:0] SEG_9   = 8'hF6;
    localparam logic [7:0] SEG_BLK = 8'h00;

    localparam logic [7:0] LCD_BLK  = 8'h20;
    localparam logic [7:0] LCD_ZERO = 8'h30;

    localparam logic [1:0] ST_OP1  = 2'b00;
    localparam logic [1:0] ST_OP2  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] ST_BAD  = 2'b11;

    // Key bit indices: digit d sits at KEY_D0 + d.
    localparam int KEY_ENTER = 0;
    localparam int KEY_CLR   = 1;
    localparam int KEY_D0    = 2;

    typedef struct packed {
        logic       is_digit;
        logic       is_clr;
        logic       is_enter;
        logic [3:0] digit;
    } key_dec_t;

    function automatic key_dec_t decode_key(input logic [N_KEYS-1:0] k);
        key_dec_t r;
        r          = '0;
        r.is_enter = k[KEY_ENTER];
        r.is_clr   = k[KEY_CLR];
        for (int d = 0; d < 10; d++) begin
            if (k[KEY_D0+d]) begin
                r.is_digit = 1'b1;
                r.digit    = 4'(d);
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/keypad_operand_entry_if.sv
// keypad_operand_entry_if: keypad-to-ALU bundle.
//   i_sw_push  raw push switches into the entry block
//   o_seg/o_lcd  echo of the last accepted key
//   o_op1/o_op2  binary operands, o_digits digits in current operand
//   o_state    entry state, o_valid operands-complete strobe, o_ovf digit-rejected strobe
// master: keypad/ALU side (drives keys, observes results)
// slave : the entry block itself
interface keypad_operand_entry_if #(
    parameter int N_DIGITS = 3,
    parameter int VAL_W    = 10
);
    import calc_pkg::*;

    localparam int DIG_W = $clog2(N_DIGITS + 1);

    logic [N_KEYS-1:0] i_sw_push;
    logic [7:0]        o_seg;
    logic [7:0]        o_lcd;
    logic [VAL_W-1:0]  o_op1;
    logic [VAL_W-1:0]  o_op2;
    logic [DIG_W-1:0]  o_digits;
    logic [1:0]        o_state;
    logic              o_valid;
    logic              o_ovf;

    modport master (
        output i_sw_push,
        input  o_seg, o_lcd, o_op1, o_op2, o_digits, o_state, o_valid, o_ovf
    );

    modport slave (
        input  i_sw_push,
        output o_seg, o_lcd, o_op1, o_op2, o_digits, o_state, o_valid, o_ovf
    );

endinterface

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus stability counter for a W-bit key vector.
//   clk, rst  clock, asynchronous active-high reset
//   i_raw     raw switch pattern
//   o_key     accepted pattern (valid together with o_evt)
//   o_evt     one-cycle strobe: a new one-hot pattern has just been accepted
module key_debounce #(
    parameter int W          = 12,
    parameter int DEB_CYCLES = 20000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_raw,
    output logic [W-1:0] o_key,
    output logic         o_evt
);

    localparam int               CNT_W   = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [W-1:0]     sync1_q, sync2_q;
    logic [W-1:0]     samp_q, samp_d;
    logic [W-1:0]     key_q, key_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_raw;
            sync2_q <= sync1_q;
            samp_q  <= samp_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter saturates at CNT_MAX, so a held pattern is re-accepted
    // every cycle; the key_q comparison keeps that from re-firing events.
    always_comb begin
        samp_d = samp_q;
        cnt_d  = cnt_q;
        accept = 1'b0;
        if (sync2_q != samp_q) begin
            samp_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            accept = 1'b1;
        end
        key_d = accept ? samp_q : key_q;
    end

    // Release (all-zero) and multi-hot patterns are accepted silently.
    assign o_evt = accept && (samp_q != key_q) && $onehot(samp_q);
    assign o_key = key_d;

endmodule

// File: rtl/keypad_operand_entry.sv
// keypad_operand_entry: two-operand decimal entry front end.
//   clk, rst  clock, asynchronous active-high reset
//   kif       slave side of keypad_operand_entry_if:
//             i_sw_push in; o_seg, o_lcd, o_op1, o_op2, o_digits,
//             o_state, o_valid, o_ovf out
// Each debounced key event updates the FSM, the current operand and the
// display registers on the following clock edge. VAL_W must satisfy
// 2**VAL_W > 10**N_DIGITS - 1 so operand*10+d never wraps.
module keypad_operand_entry
    import calc_pkg::*;
#(
    parameter int N_DIGITS   = 3,
    parameter int VAL_W      = 10,
    parameter int DEB_CYCLES = 20000
) (
    input logic                  clk,
    input logic                  rst,
    keypad_operand_entry_if.slave kif
);

    localparam int DIG_W = $clog2(N_DIGITS + 1);

    logic [N_KEYS-1:0] key_new;
    logic              key_evt;
    key_dec_t          kd;

    logic [1:0]       state_q, state_d;
    logic [VAL_W-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [VAL_W-1:0] cur_val, acc_val;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic [7:0]       seg_q, seg_d, lcd_q, lcd_d;
    logic             valid_q, valid_d, ovf_q, ovf_d;
    logic             all_clr;

    key_debounce #(
        .W          (N_KEYS),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk   (clk),
        .rst   (rst),
        .i_raw (kif.i_sw_push),
        .o_key (key_new),
        .o_evt (key_evt)
    );

    assign kd = decode_key(key_new);

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OP1;
            op1_q   <= '0;
            op2_q   <= '0;
            dig_q   <= '0;
            seg_q   <= SEG_BLK;
            lcd_q   <= LCD_BLK;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
            lcd_q   <= lcd_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic. Any key in DONE performs an all-clear, which lands
    // in OP1 (a digit is then entered as op1's first digit).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OP1:  if (key_evt && kd.is_enter) state_d = ST_OP2;
            ST_OP2:  if (key_evt && kd.is_enter) state_d = ST_DONE;
            ST_DONE: if (key_evt)                state_d = ST_OP1;
            default:                             state_d = ST_OP1;
        endcase
    end

    // Operand, digit-count and display updates.
    always_comb begin
        op1_d   = op1_q;
        op2_d   = op2_q;
        dig_d   = dig_q;
        seg_d   = seg_q;
        lcd_d   = lcd_q;
        valid_d = 1'b0;
        ovf_d   = 1'b0;

        cur_val = (state_q == ST_OP2) ? op2_q : op1_q;
        acc_val = cur_val * VAL_W'(10) + VAL_W'(kd.digit);

        all_clr = (state_q == ST_BAD) || (key_evt && state_q == ST_DONE);
        if (all_clr) begin
            op1_d = '0;
            op2_d = '0;
            dig_d = '0;
            seg_d = SEG_BLK;
            lcd_d = LCD_BLK;
        end

        if (key_evt && state_q != ST_BAD) begin
            if (kd.is_digit) begin
                seg_d = seg_of(kd.digit);
                lcd_d = LCD_ZERO + {4'h0, kd.digit};
                if (state_q == ST_DONE) begin
                    op1_d = VAL_W'(kd.digit);
                    dig_d = DIG_W'(1);
                end else if (dig_q < DIG_W'(N_DIGITS)) begin
                    if (state_q == ST_OP2) op2_d = acc_val;
                    else                   op1_d = acc_val;
                    dig_d = dig_q + DIG_W'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (kd.is_clr && state_q != ST_DONE) begin
                if (state_q == ST_OP2) op2_d = '0;
                else                   op1_d = '0;
                dig_d = '0;
                seg_d = SEG_BLK;
                lcd_d = LCD_BLK;
            end else if (kd.is_enter && state_q != ST_DONE) begin
                dig_d   = '0;
                valid_d = (state_q == ST_OP2);
            end
        end
    end

    assign kif.o_state  = state_q;
    assign kif.o_op1    = op1_q;
    assign kif.o_op2    = op2_q;
    assign kif.o_digits = dig_q;
    assign kif.o_seg    = seg_q;
    assign kif.o_lcd    = lcd_q;
    assign kif.o_valid  = valid_q;
    assign kif.o_ovf    = ovf_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// tb_keypad_operand_entry: directed stimulus with a behavioural key-entry
// model compared against the DUT on every cycle, plus literal checks.
module tb_keypad_operand_entry;

    localparam int N_DIGITS = 3;
    localparam int VAL_W    = 10;
    localparam int DEB      = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keypad_operand_entry_if #(.N_DIGITS(N_DIGITS), .VAL_W(VAL_W)) bus ();

    keypad_operand_entry #(
        .N_DIGITS   (N_DIGITS),
        .VAL_W      (VAL_W),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int valid_cnt = 0;
    int ovf_cnt   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A pattern counts as pressed once it has stood on the raw inputs for
    // DEB+1 consecutive clock samples; the synchroniser delays this by two
    // samples. The key is then applied to the entry rules below.
    logic [7:0]  seg_tbl [0:9] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                   8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
    logic [11:0] hist [0:DEB+2];
    logic [11:0] m_acc;
    int          m_op1, m_op2, m_dig, m_state;
    logic [7:0]  m_seg, m_lcd;
    bit          m_valid, m_ovf;

    task automatic m_clear_all();
        m_op1 = 0; m_op2 = 0; m_dig = 0; m_state = 0;
        m_seg = 8'h00; m_lcd = 8'h20;
    endtask

    task automatic m_reset();
        m_clear_all();
        m_valid = 1'b0; m_ovf = 1'b0; m_acc = '0;
        for (int j = 0; j <= DEB + 2; j++) hist[j] = '0;
    endtask

    task automatic apply_key(input logic [11:0] p);
        bit was_done;
        int d;
        was_done = (m_state == 2);
        if (was_done) m_clear_all();
        if (p[0]) begin
            if (!was_done) begin
                if (m_state == 0) m_state = 1;
                else begin m_state = 2; m_valid = 1'b1; end
                m_dig = 0;
            end
        end else if (p[1]) begin
            if (!was_done) begin
                if (m_state == 0) m_op1 = 0; else m_op2 = 0;
                m_dig = 0; m_seg = 8'h00; m_lcd = 8'h20;
            end
        end else begin
            d = 0;
            for (int b = 2; b < 12; b++) if (p[b]) d = b - 2;
            m_seg = seg_tbl[d];
            m_lcd = 8'(8'h30 + d);
            if (m_dig < N_DIGITS) begin
                if (m_state == 0) m_op1 = m_op1 * 10 + d;
                else              m_op2 = m_op2 * 10 + d;
                m_dig++;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    initial begin
        bit stable;
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else begin
                for (int j = DEB + 2; j > 0; j--) hist[j] = hist[j-1];
                hist[0] = bus.i_sw_push;
                m_valid = 1'b0;
                m_ovf   = 1'b0;
                stable  = 1'b1;
                for (int j = 3; j <= DEB + 2; j++) if (hist[j] != hist[2]) stable = 1'b0;
                if (stable && hist[2] != m_acc) begin
                    m_acc = hist[2];
                    if ($countones(hist[2]) == 1) apply_key(hist[2]);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) valid_cnt++;
            if (bus.o_ovf === 1'b1)   ovf_cnt++;
            if (chk_en) begin
                check("cyc_seg",    32'(bus.o_seg),    32'(m_seg));
                check("cyc_lcd",    32'(bus.o_lcd),    32'(m_lcd));
                check("cyc_op1",    32'(bus.o_op1),    32'(m_op1));
                check("cyc_op2",    32'(bus.o_op2),    32'(m_op2));
                check("cyc_digits", 32'(bus.o_digits), 32'(m_dig));
                check("cyc_state",  32'(bus.o_state),  32'(m_state));
                check("cyc_valid",  32'(bus.o_valid),  32'(m_valid));
                check("cyc_ovf",    32'(bus.o_ovf),    32'(m_ovf));
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [11:0] dk(input int d);
        logic [11:0] one;
        one = 12'h001;
        return one << (d + 2);
    endfunction

    localparam logic [11:0] K_ENT = 12'h001;
    localparam logic [11:0] K_CLR = 12'h002;

    task automatic drive(input logic [11:0] p, input int n);
        @(negedge clk);
        bus.i_sw_push = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input logic [11:0] p);
        drive(p, 10);
        drive(12'h000, 10);
    endtask

    initial begin
        int base;
        bus.i_sw_push = '0;

        // 1: reset values
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        #1;
        check("rst_seg",   32'(bus.o_seg),    32'h00);
        check("rst_lcd",   32'(bus.o_lcd),    32'h20);
        check("rst_op1",   32'(bus.o_op1),    0);
        check("rst_op2",   32'(bus.o_op2),    0);
        check("rst_state", 32'(bus.o_state),  0);
        check("rst_valid", 32'(bus.o_valid),  0);
        check("rst_ovf",   32'(bus.o_ovf),    0);
        @(negedge clk); #1 rst = 1'b0;

        // 2: 1,2,3,enter,4,5,enter
        tap(dk(1)); tap(dk(2)); tap(dk(3));
        check("t2_op1_123", 32'(bus.o_op1), 123);
        check("t2_dig3",    32'(bus.o_digits), 3);
        tap(K_ENT);
        check("t2_state_op2", 32'(bus.o_state), 1);
        tap(dk(4)); tap(dk(5));
        check("t2_lcd_35", 32'(bus.o_lcd), 32'h35);
        check("t2_seg_5",  32'(bus.o_seg), 32'hB6);
        base = valid_cnt;
        tap(K_ENT);
        check("t2_op1",       32'(bus.o_op1), 123);
        check("t2_op2",       32'(bus.o_op2), 45);
        check("t2_done",      32'(bus.o_state), 2);
        check("t2_valid_one", 32'(valid_cnt - base), 1);

        // 3: 9,8,7,6 from DONE -> op1=987, ovf on 6
        base = ovf_cnt;
        tap(dk(9));
        check("t3_first_op1", 32'(bus.o_op1), 9);
        check("t3_op2_clr",   32'(bus.o_op2), 0);
        tap(dk(8)); tap(dk(7)); tap(dk(6));
        check("t3_op1",     32'(bus.o_op1), 987);
        check("t3_dig",     32'(bus.o_digits), 3);
        check("t3_ovf_one", 32'(ovf_cnt - base), 1);
        check("t3_seg_6",   32'(bus.o_seg), 32'hBE);
        check("t3_lcd_6",   32'(bus.o_lcd), 32'h36);

        // 4: glitch then long hold
        tap(K_CLR);
        check("t4_clr_op1", 32'(bus.o_op1), 0);
        drive(dk(2), 2);
        drive(12'h000, 20);
        check("t4_glitch_dig", 32'(bus.o_digits), 0);
        check("t4_glitch_lcd", 32'(bus.o_lcd), 32'h20);
        drive(dk(2), 100);
        drive(12'h000, 10);
        check("t4_hold_op1", 32'(bus.o_op1), 2);
        check("t4_hold_dig", 32'(bus.o_digits), 1);

        // 5: multi-hot ignored, clear entry in OP2, enter, enter
        drive(12'h801, 20);
        drive(12'h000, 10);
        check("t5_mh_state", 32'(bus.o_state), 0);
        check("t5_mh_op1",   32'(bus.o_op1), 2);
        check("t5_mh_lcd",   32'(bus.o_lcd), 32'h32);
        tap(K_ENT); tap(dk(4)); tap(dk(5));
        check("t5_op2_45", 32'(bus.o_op2), 45);
        tap(K_CLR);
        check("t5_ce_op2", 32'(bus.o_op2), 0);
        check("t5_ce_op1", 32'(bus.o_op1), 2);
        check("t5_ce_seg", 32'(bus.o_seg), 32'h00);
        base = valid_cnt;
        tap(K_ENT);
        check("t5_done",  32'(bus.o_state), 2);
        check("t5_valid", 32'(valid_cnt - base), 1);
        tap(K_ENT);
        check("t5_ac_state", 32'(bus.o_state), 0);
        check("t5_ac_op1",   32'(bus.o_op1), 0);
        check("t5_ac_op2",   32'(bus.o_op2), 0);

        // 6: reset mid-debounce, key held through release
        tap(dk(1)); tap(dk(2));
        check("t6_op1_12", 32'(bus.o_op1), 12);
        @(negedge clk);
        bus.i_sw_push = dk(3);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_op1", 32'(bus.o_op1), 0);
        check("t6_rst_dig", 32'(bus.o_digits), 0);
        check("t6_rst_lcd", 32'(bus.o_lcd), 32'h20);
        @(negedge clk); #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_op1_3", 32'(bus.o_op1), 3);
        check("t6_lcd_3", 32'(bus.o_lcd), 32'h33);
        drive(12'h000, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
